alu_cmd_driver: RTL
===================

Name: alu_cmd_driver

Overview:
Initiator side of the 16-bit ALU operand interface. Accepts operation commands over a valid/ready port and drives the ALU's A/B/opcode inputs. Waits a programmable settle time, then samples Result/V/N and returns them with the command tag over a valid/ready response port. Sits between a sequencer or CPU-style controller and the combinational ALU; also keeps operation and overflow statistics.

Parameters:
DW, 16, operand/result width
OPW, 4, opcode width
TAGW, 4, command tag width
SETTLE, 1, cycles between driving ALU inputs and sampling outputs (legal 1..15)
IDLE_OP, 4'hF, opcode driven while no command is active (ALU no-op)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  driver can accept a command
cmd_a  in  DW  operand A
cmd_b  in  DW  operand B
cmd_op  in  OPW  ALU opcode
cmd_tag  in  TAGW  caller tag, returned unchanged
cmd_chain  in  1  use previous result as A (only with the optional feature; otherwise ignored)
alu_a  out  DW  to ALU A
alu_b  out  DW  to ALU B
alu_op  out  OPW  to ALU opcode
alu_result  in  DW  from ALU Result
alu_v  in  1  from ALU V (overflow)
alu_n  in  1  from ALU N (negative)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  DW  captured result
rsp_v  out  1  captured V
rsp_n  out  1  captured N
rsp_tag  out  TAGW  tag of the command
busy  out  1  high in SETTLE or RESP
op_cnt  out  16  completed operations, wraps 16'hFFFF->0
ovf_cnt  out  8  captures with V=1, saturates at 255

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, cmd_ready=1, busy=0
  - alu_a=0, alu_b=0, alu_op=IDLE_OP
  - rsp_valid=0, rsp_result=0, rsp_v=0, rsp_n=0, rsp_tag=0
  - op_cnt=0, ovf_cnt=0, settle counter=0
- Reset takes effect immediately mid-operation. Any in-flight command or pending response is discarded.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge k: register cmd_a/cmd_b/cmd_op onto alu_a/alu_b/alu_op, latch the tag, load counter=SETTLE-1, go to SETTLE.
- SETTLE:
  - cmd_ready=0. ALU inputs are held stable.
  - Counter decrements each cycle.
  - At the edge where counter==0 (edge k+SETTLE), capture alu_result/alu_v/alu_n into the rsp_* registers, set rsp_valid=1, increment op_cnt, and increment ovf_cnt if alu_v=1 (unless already 255). Go to RESP.
- RESP:
  - rsp_valid=1. rsp_* outputs and alu_* outputs are held stable while rsp_ready=0, with no limit on the stall.
  - On rsp_valid&rsp_ready: clear rsp_valid, drive alu_op=IDLE_OP (alu_a/alu_b keep their values), go to IDLE.
  - cmd_ready stays 0 in RESP. A command and a response never complete in the same cycle.
- Latency and throughput:
  - Latency from accept edge to rsp_valid rising is SETTLE cycles.
  - Minimum command spacing is SETTLE+2 cycles with rsp_ready tied high.
- cmd_valid asserted outside IDLE has no effect. The command must stay presented until cmd_ready is high.
- Opcodes are passed through untouched. The driver does not decode them.
- Out-of-range SETTLE (0 or >15) is an elaboration error.

Optional Feature:
- Macro ALU_DRV_CHAIN_EN.
- Defined:
  - A DW-bit last_result register (reset 0) is loaded on every capture.
  - A command accepted with cmd_chain=1 drives alu_a=last_result instead of cmd_a.
  - cmd_chain=1 as the first command after reset uses 0.
- Undefined: no last_result register; cmd_chain is ignored and alu_a=cmd_a always.

Test Plan:
- Reset, then idle -> alu_op=4'hF, alu_a=alu_b=0, rsp_valid=0, cmd_ready=1, op_cnt=0.
- Command ADD A=16'h7FFF B=16'd30, SETTLE=1, rsp_ready=1 -> rsp_valid one cycle after accept; rsp_result=16'h801D, rsp_v=1, rsp_n=1; ovf_cnt=1, op_cnt=1; tag echoed.
- SUB 120-100 then AND 16'h7FED&16'h1111, with rsp_ready held low 5 cycles on the first -> first response held stable with result 16'd20; cmd_ready=0 throughout the stall; second result 16'h1101; commands issued back-to-back are spaced SETTLE+2 cycles apart.
- SETTLE=3, drive changing cmd_* while busy -> alu_* stay stable for 3 cycles, and extra cmd_valid is ignored.
- Deassert rst_n during SETTLE -> all outputs return to reset values immediately; no response emerges afterward.
- ALU_DRV_CHAIN_EN defined: ADD 1+1, then ADD cmd_chain=1 B=3 -> second rsp_result=16'd5. Undefined: same stimulus with cmd_a=0 -> 16'd3.

Source files
------------

// File: rtl/alu_cmd_driver_if.sv
// Command/response handshake bundle between a controller
// and the ALU command driver.
interface alu_cmd_driver_if #(
  parameter int DW   = 16,
  parameter int OPW  = 4,
  parameter int TAGW = 4
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [DW-1:0]   cmd_a;
  logic [DW-1:0]   cmd_b;
  logic [OPW-1:0]  cmd_op;
  logic [TAGW-1:0] cmd_tag;
  logic            cmd_chain;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_result;
  logic            rsp_v;
  logic            rsp_n;
  logic [TAGW-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_tag, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result,
    input  rsp_v, rsp_n, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_tag, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result,
    output rsp_v, rsp_n, rsp_tag
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Drives a combinational ALU, waits SETTLE cycles, returns result.
// Define ALU_DRV_CHAIN_EN to let cmd_chain feed back the last result.
module alu_cmd_driver #(
  parameter int             DW      = 16,
  parameter int             OPW     = 4,
  parameter int             TAGW    = 4,
  parameter int             SETTLE  = 1,
  parameter logic [OPW-1:0] IDLE_OP = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_driver_if.slave  bus,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic             busy,
  output logic [15:0]      op_cnt,
  output logic [7:0]       ovf_cnt
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("alu_cmd_driver: SETTLE must be 1..15");
  end

  localparam logic [3:0] CNT_LD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [TAGW-1:0] tag_q;
  logic [DW-1:0]   res_q;
  logic            v_q;
  logic            n_q;
  logic [TAGW-1:0] rtag_q;
  logic [DW-1:0]   a_sel;
  logic            accept;
  logic            capture;
  logic            done;

`ifdef ALU_DRV_CHAIN_EN
  logic [DW-1:0] last_result;
  assign a_sel = bus.cmd_chain ? last_result : bus.cmd_a;
`else
  assign a_sel = bus.cmd_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: if (bus.cmd_valid) begin
        accept    = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: if (cnt == 4'd0) begin
        capture   = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.cmd_ready  = (state == S_IDLE);
  assign bus.rsp_valid  = (state == S_RESP);
  assign busy           = (state != S_IDLE);
  assign bus.rsp_result = res_q;
  assign bus.rsp_v      = v_q;
  assign bus.rsp_n      = n_q;
  assign bus.rsp_tag    = rtag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= IDLE_OP;
      tag_q   <= '0;
      cnt     <= '0;
      res_q   <= '0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      rtag_q  <= '0;
      op_cnt  <= '0;
      ovf_cnt <= '0;
`ifdef ALU_DRV_CHAIN_EN
      last_result <= '0;
`endif
    end else begin
      if (accept) begin
        alu_a  <= a_sel;
        alu_b  <= bus.cmd_b;
        alu_op <= bus.cmd_op;
        tag_q  <= bus.cmd_tag;
        cnt    <= CNT_LD;
      end
      if (state == S_SETTLE && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (capture) begin
        res_q  <= alu_result;
        v_q    <= alu_v;
        n_q    <= alu_n;
        rtag_q <= tag_q;
        op_cnt <= op_cnt + 16'd1;
        if (alu_v && ovf_cnt != 8'hFF)
          ovf_cnt <= ovf_cnt + 8'd1;
`ifdef ALU_DRV_CHAIN_EN
        last_result <= alu_result;
`endif
      end
      // operands stay put so the ALU output does not glitch
      if (done)
        alu_op <= IDLE_OP;
    end
  end

endmodule
